// File: rtl/lfsr_stream.sv
// LFSR pseudo-random generator with a valid/ready output stream, runtime taps,
// Fibonacci/Galois mode and STEPS shifts per beat. Optional LFSR_PERIOD_EN adds beat_cnt/period_hit.
module lfsr_stream #(
    parameter int NBITS = 8,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] seed,
    input  logic [NBITS-1:0] taps,
    input  logic             mode,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic [STEPS-1:0] out_bits,
    output logic             lockup
`ifdef LFSR_PERIOD_EN
    ,
    output logic [NBITS-1:0] beat_cnt,
    output logic             period_hit
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [NBITS-1:0] r_q;
    logic             r_out_val;
    logic             r_lockup;

    logic [NBITS-1:0] w_walk;
    logic [STEPS-1:0] w_bits;
    logic             w_accept;
    logic [NBITS-1:0] w_q_next;

    function automatic logic [NBITS-1:0] f_step(input logic [NBITS-1:0] q,
                                                input logic [NBITS-1:0] tp,
                                                input logic             md);
        if (md)
            return {1'b0, q[NBITS-1:1]} ^ (q[0] ? tp : '0);
        else
            return {^(q & tp), q[NBITS-1:1]};
    endfunction

    // Unroll STEPS single shifts; w_walk ends as the state after a full beat.
    always_comb begin
        w_walk = r_q;
        w_bits = '0;
        for (int j = 0; j < STEPS; j++) begin
            w_bits[j] = w_walk[0];
            w_walk    = f_step(w_walk, taps, mode);
        end
    end

    assign w_accept = r_out_val && out_rdy;
    assign w_q_next = w_accept ? w_walk : r_q;

    // out_val is registered as (next state is RUN) && (next q != 0).
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q       <= seed;
            r_state   <= IDLE;
            r_out_val <= 1'b0;
            r_lockup  <= 1'b0;
        end else begin
            r_q <= w_q_next;
            case (r_state)
                IDLE: begin
                    if (start && !stop && (r_q != '0)) begin
                        r_state   <= RUN;
                        r_out_val <= 1'b1;
                    end else if (start && !stop) begin
                        r_state  <= FAULT;
                        r_lockup <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_q == '0) begin
                        r_state   <= FAULT;
                        r_out_val <= 1'b0;
                        r_lockup  <= 1'b1;
                    end else if (stop) begin
                        r_state   <= IDLE;
                        r_out_val <= 1'b0;
                    end else begin
                        r_out_val <= (w_q_next != '0);
                    end
                end
                default: begin
                    r_state   <= FAULT;
                    r_out_val <= 1'b0;
                    r_lockup  <= 1'b1;
                end
            endcase
        end
    end

`ifdef LFSR_PERIOD_EN
    logic [NBITS-1:0] r_seed_cap;
    logic [NBITS-1:0] r_beat_cnt;
    logic             r_period_hit;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_seed_cap   <= seed;
            r_beat_cnt   <= '0;
            r_period_hit <= 1'b0;
        end else begin
            r_period_hit <= w_accept && (w_walk == r_seed_cap);
            if (w_accept && (r_beat_cnt != '1))
                r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign beat_cnt   = r_beat_cnt;
    assign period_hit = r_period_hit;
`endif

    assign out_val  = r_out_val;
    assign out_data = r_q;
    assign out_bits = w_bits;
    assign lockup   = r_lockup;

endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
Parametrised LFSR pseudo-random generator with a valid/ready output stream. Supports runtime-programmable taps, Fibonacci or Galois mode, and STEPS shifts per accepted beat. The all-zero lock-up state is detected and the generator is fenced off until it is reseeded. It sits between the seedable shift-register primitives and downstream consumers such as test-pattern sinks and scramblers.

Parameters:
NBITS  8  state width; legal range 3..32
STEPS  1  single-bit shifts applied per accepted beat; legal range 1..NBITS

Ports:
clk        input   1      clock
rst        input   1      reset, synchronous, active-high
seed       input   NBITS  value loaded into state on rst or load
taps       input   NBITS  feedback mask; bit i set means stage i participates
mode       input   1      0 = Fibonacci, 1 = Galois
load       input   1      synchronous reseed: state <= seed, FSM <= IDLE
start      input   1      request to run
stop       input   1      request to halt
out_val    output  1      beat available
out_rdy    input   1      consumer accepts beat
out_data   output  NBITS  current state q
out_bits   output  STEPS  bits emitted by this beat, LSB first
lockup     output  1      state is all-zero; generator fenced

Behaviour:
- Single step, right shift:
  - Fibonacci: fb = XOR-reduce(q & taps); next = {fb, q[NBITS-1:1]}.
  - Galois: next = {1'b0, q[NBITS-1:1]} ^ (q[0] ? taps : 0). Software sets taps[NBITS-1] = 1 for Galois.
- out_bits[j] = bit 0 of the state after j single steps from q (j = 0..STEPS-1). Combinational from q, taps and mode.
- Accept: out_val && out_rdy. On accept, q <= state after STEPS single steps, computed in one cycle. With no accept, q holds.
- FSM states:
  - IDLE
    - out_val = 0.
    - start && q != 0 -> RUN.
    - start && q == 0 -> FAULT.
    - start && stop together: stop wins; stay IDLE.
  - RUN
    - out_val = (q != 0).
    - q == 0 -> FAULT. This is reachable only via a taps change.
    - stop -> IDLE. A beat accepted in the same cycle still advances q.
    - start is ignored.
  - FAULT
    - out_val = 0, lockup = 1.
    - Exits only via load or rst.
- load: q <= seed, FSM <= IDLE, lockup cleared next cycle. load has priority over start, stop and accept; q does not advance in that cycle.
- rst: q <= seed, FSM <= IDLE.
  - Outputs from the cycle after rst: out_val = 0, lockup = 0, out_data = seed.
  - If seed == 0, lockup stays 0 until start moves the FSM to FAULT.
  - rst mid-run discards any pending beat.
- taps and mode are sampled live. A change takes effect on the next accepted beat; a change in RUN is legal.
- lockup = (FSM == FAULT), registered.

Optional Feature:
Macro LFSR_PERIOD_EN.
- Defined: adds two outputs.
  - beat_cnt (NBITS bits): counts accepted beats, saturates at all-ones, clears on rst or load.
  - period_hit (1 bit): pulses for one cycle in the cycle after an accept that returns q to the seed captured at the last rst or load. beat_cnt then reads the period in beats and does not clear on period_hit.
- Not defined: neither port exists, and there is no captured-seed register or counter logic.

Test Plan:
1. NBITS=8, STEPS=1, Fibonacci, taps=8'h1D, seed=8'h01, out_rdy=1, start -> out_data 01, 80, 40, ... on consecutive beats; state returns to 01 after exactly 255 beats; with LFSR_PERIOD_EN, period_hit pulses and beat_cnt=255.
2. Galois, taps=8'hB8, seed=8'h01 -> out_data 01, B8, 5C; period 255.
3. STEPS=2, Fibonacci, taps=8'h1D, seed=8'h01 -> first beat shows out_bits=2'b01; out_data after one accept is 8'h40.
4. Backpressure: RUN with out_rdy=0 for 5 cycles -> out_val=1 and out_data frozen; on out_rdy=1, advances exactly once per accepted cycle.
5. seed=0, rst, start -> FAULT next cycle: lockup=1, out_val=0. Then seed=8'h01 with load -> IDLE; lockup=0 next cycle; start resumes at 01.
6. rst asserted mid-RUN together with out_rdy=1 -> no advance; out_data=seed, out_val=0 the next cycle. stop with accept in the same cycle -> q advances once, then IDLE.
